// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and status bit indices shared by alu_seq.
package alu_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOTB = 3'b011;
    localparam logic [2:0] OP_LSL  = 3'b100;
    localparam logic [2:0] OP_LSR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;
    localparam int STAT_N = 2;
    localparam int STAT_V = 1;
    localparam int STAT_Z = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: W-iteration shift-add unsigned multiplier; first partial product is taken on start,
// so done is high in the W-th cycle after start.
module alu_mul_iter #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] prod
);
    localparam int CW = $clog2(W);
    logic [2*W-1:0] acc, ma;
    logic [W-1:0]   mb;
    logic [CW-1:0]  cnt;
    logic           run;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run <= 1'b0;
            cnt <= '0;
            acc <= '0;
            ma  <= '0;
            mb  <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= CW'(W - 1);
            acc <= b[0] ? {{W{1'b0}}, a} : '0;
            ma  <= {{(W-1){1'b0}}, a, 1'b0};
            mb  <= b >> 1;
        end else if (run) begin
            // mb is already zero on the final (done) cycle, so acc stays put there
            run <= cnt != '0;
            cnt <= cnt - CW'(1);
            acc <= acc + (mb[0] ? ma : '0);
            ma  <= ma << 1;
            mb  <= mb >> 1;
        end
    end
    assign done = run & (cnt == '0);
    assign prod = acc;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake and registered {N,V,Z} status.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise MUL reports op_err.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W   = 16,
    parameter int SHW = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] ain,
    input  logic [W-1:0] bin,
    input  logic [2:0]   aluop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [2:0]   stat,
    output logic         op_err
);
    state_t state, state_nxt;
    logic accept, is_mul, mul_go, mul_fin, load;
    logic [W-1:0] bb, sum, res, res_fin;
    logic v, v_fin, err, err_fin;
    logic [SHW-1:0] sh;
    logic mul_done;
    logic [2*W-1:0] prod;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
    alu_mul_iter #(.W(W)) u_mul (
        .clk(clk),
        .reset_n(reset_n),
        .start(mul_go),
        .a(ain),
        .b(bin),
        .done(mul_done),
        .prod(prod)
    );
`else
    localparam bit MUL_EN = 1'b0;
    assign mul_done = 1'b0;
    assign prod = '0;
`endif
    assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    assign out_valid = state == ST_DONE;
    assign accept    = in_valid & in_ready;
    assign is_mul    = aluop == OP_MUL;
    assign mul_go    = accept & is_mul & MUL_EN;
    assign mul_fin   = (state == ST_BUSY) & mul_done;
    assign load      = mul_fin | (accept & ~mul_go);
    assign sh        = bin[SHW-1:0];
    assign bb        = (aluop == OP_SUB) ? ~bin : bin;
    assign sum       = ain + bb + {{(W-1){1'b0}}, aluop == OP_SUB};
    always_comb begin
        res = '0;
        v   = 1'b0;
        err = 1'b0;
        case (aluop)
            OP_ADD, OP_SUB: begin
                res = sum;
                v   = (ain[W-1] == bb[W-1]) & (sum[W-1] != ain[W-1]);
            end
            OP_AND:  res = ain & bin;
            OP_NOTB: res = ~bin;
            OP_LSL:  res = ain << sh;
            OP_LSR:  res = ain >> sh;
            OP_ASR:  res = $unsigned($signed(ain) >>> sh);
            default: err = ~MUL_EN;
        endcase
    end
    assign res_fin = mul_fin ? prod[W-1:0] : res;
    assign v_fin   = mul_fin ? |prod[2*W-1:W] : v;
    assign err_fin = ~mul_fin & err;
    always_comb begin
        state_nxt = state;
        state_nxt = mul_go ? ST_BUSY : load ? ST_DONE : (out_valid & out_ready) ? ST_IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            out    <= '0;
            stat   <= '0;
            op_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out          <= res_fin;
                stat[STAT_N] <= res_fin[W-1];
                stat[STAT_V] <= v_fin;
                stat[STAT_Z] <= res_fin == '0;
                op_err       <= err_fin;
            end
        end
    end
endmodule
